ifft_codec_packer: RTL and testbench
====================================

Name: ifft_codec_packer

Overview:
Downstream stage of the per-channel IFFT in the DJ pipeline. It takes the IFFT's complex output stream and extracts the real part. It rounds and saturates that value to codec sample width, tags frame position from the IFFT sync pulse, and buffers samples in a small FIFO. It presents samples to the codec-side FIFO sink over a valid/ready handshake and reports frame completion, clipping, overflow and sync errors.

Parameters:
IFFT_OWIDTH, 26, width of each real/imag component of the IFFT result
OUT_WIDTH, 16, codec sample width
SHIFT, 10, LSBs dropped from the real part (must satisfy 1 <= SHIFT <= IFFT_OWIDTH-1)
LGWIDTH, 9, log2 of frame length (512 samples)
LGDEPTH, 4, log2 of output FIFO depth (16 entries)

Ports:
clk  in  1  master clock
reset  in  1  asynchronous, active-low reset
i_ce  in  1  IFFT output-valid strobe, one sample per asserted cycle, cannot be stalled
i_result  in  2*IFFT_OWIDTH  {re, im}; re = [2*IFFT_OWIDTH-1:IFFT_OWIDTH], signed
i_sync  in  1  marks the first sample of a frame, qualified by i_ce
o_stream  out  OUT_WIDTH  signed sample to codec FIFO sink
o_valid  out  1  o_stream holds a valid sample
i_ready  in  1  codec FIFO sink ready
i_clear  in  1  synchronous clear of sticky status flags
o_frame_done  out  1  one-cycle pulse when the last sample of a frame leaves stage 2
o_clipped  out  1  sticky, set when any sample saturated
o_overflow  out  1  sticky, set when a sample was dropped on a full FIFO
o_sync_err  out  1  sticky, set when i_sync arrives at an index other than 0
o_level  out  LGDEPTH+1  current FIFO occupancy

Behaviour:
- Reset (reset==0, async): state = WAIT_SYNC, index = 0, pipeline valids = 0, FIFO empty. All outputs are 0.
- FSM WAIT_SYNC: samples arriving with i_ce && !i_sync are discarded. On i_ce && i_sync, that sample is accepted as index 0 and the FSM moves to RUN.
- FSM RUN: every i_ce sample is accepted and index increments modulo 2^LGWIDTH.
- i_sync while in RUN with index != 2^LGWIDTH-1 (the expected next index is not 0): set o_sync_err and treat the sample as index 0 (resync). No flush occurs.
- Stage 1 (register): sum = sign-extended re + (1 << (SHIFT-1)). The sum is kept at IFFT_OWIDTH+1 bits. The frame-last tag (index == 2^LGWIDTH-1) travels with the sample.
- Stage 2 (register): q = sum >>> SHIFT (arithmetic shift).
  - If q > 2^(OUT_WIDTH-1)-1, output max positive; if q < -2^(OUT_WIDTH-1), output min negative. In either case set o_clipped.
  - Rounding is round-half-up, toward +inf on ties.
- FIFO write occurs on the cycle after stage 2 valid. Latency from i_ce to o_valid (FIFO empty) is 3 cycles.
- FIFO full at write time: the sample is dropped and o_overflow is set. Exception: a simultaneous pop frees a slot, so push and pop both occur, the sample is accepted, and no overflow is flagged.
- o_frame_done pulses when a frame-last sample exits stage 2, whether it is written or dropped.
- Output: show-ahead FIFO. o_stream equals the head entry. Pop on o_valid && i_ready.
  - o_stream and o_valid hold stable while o_valid && !i_ready.
  - Empty FIFO: o_valid = 0, and o_stream holds its last value.
- Read/write pointers have LGDEPTH+1 bits and wrap naturally. o_level = wptr - rptr. Full when o_level == 2^LGDEPTH.
- i_clear: clears o_clipped, o_overflow and o_sync_err next cycle. Set and clear in the same cycle resolves to set. i_clear does not affect FSM, index or FIFO.
- A reset assertion mid-frame discards the pipeline and FIFO contents. After release, the block waits for a new i_sync.

Decomposition:
- Shared package dj_pkg:
  - IFFT_OWIDTH, OUT_WIDTH, LGWIDTH defaults
  - state enum {WAIT_SYNC, RUN}
  - sample typedef (signed OUT_WIDTH)
- Sub-module dj_sample_fifo: parameterised synchronous show-ahead FIFO exposing push, pop, full, empty and level. It uses the same async active-low reset.

Test Plan:
1. Reset release, then i_ce samples without i_sync -> no FIFO writes and o_valid stays 0. First i_sync sample re=5120 -> o_stream=5, o_valid high 3 cycles later.
2. Rounding with SHIFT=10 and i_ready=1: re=1535 -> 1; re=1536 -> 2; re=-1536 -> -1; re=-1537 -> -2. o_clipped stays 0.
3. re=33554431 -> o_stream=16'h7FFF and o_clipped=1; re=-33554432 -> 16'h8000. Then i_clear -> o_clipped=0 next cycle.
4. i_ready=0 with 20 consecutive i_ce samples -> o_level=16 and o_overflow=1 with 4 samples dropped. Raising i_ready then pops samples 0..15 in order, one per cycle.
5. Full 512-sample frame after sync -> exactly one o_frame_done pulse, 2 cycles after the 512th i_ce.
6. i_sync injected at index 100 -> o_sync_err=1, and the following frame_done occurs 511 samples after the resync sample. An async reset asserted mid-frame -> all outputs 0 immediately and the FSM returns to WAIT_SYNC.

Source files
------------

// File: rtl/dj_pkg.sv
// Shared types and default widths for the DJ pipeline codec-side stages.
package dj_pkg;

    localparam int IFFT_OWIDTH_DEF = 26;
    localparam int OUT_WIDTH_DEF   = 16;
    localparam int LGWIDTH_DEF     = 9;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_t;

    typedef logic signed [OUT_WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/ifft_codec_packer_if.sv
// Sample stream from the packer to the codec FIFO sink.
interface ifft_codec_packer_if #(
    parameter int OUT_WIDTH = dj_pkg::OUT_WIDTH_DEF
) ();

    // A sample transfers on every clk edge where o_valid && i_ready; while
    // o_valid && !i_ready the master holds o_stream and o_valid stable.
    logic signed [OUT_WIDTH-1:0] o_stream;
    logic                        o_valid;
    logic                        i_ready;

    modport master (
        output o_stream,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_stream,
        input  o_valid,
        output i_ready
    );

endinterface

// File: rtl/dj_sample_fifo.sv
// Synchronous show-ahead FIFO; head shows the oldest entry, or the last
// popped value while empty.
module dj_sample_fifo #(
    parameter int WIDTH   = 16,
    parameter int LGDEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head,
    output logic               full,
    output logic               empty,
    output logic [LGDEPTH:0]   level
);

    localparam int DEPTH = 1 << LGDEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LGDEPTH:0] wptr;
    logic [LGDEPTH:0] rptr;
    logic [WIDTH-1:0] hold;
    logic             do_push;
    logic             do_pop;

    assign level = wptr - rptr;
    assign full  = (level == (LGDEPTH+1)'(DEPTH));
    assign empty = (level == '0);

    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? hold : mem[rptr[LGDEPTH-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            hold <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
                hold <= mem[rptr[LGDEPTH-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[LGDEPTH-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ifft_codec_packer.sv
// IFFT output to codec packer: real-part extraction, round-half-up and
// saturation to codec width, frame tagging from sync, and output buffering.
module ifft_codec_packer
    import dj_pkg::*;
#(
    parameter int IFFT_OWIDTH = IFFT_OWIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int SHIFT       = 10,
    parameter int LGWIDTH     = LGWIDTH_DEF,
    parameter int LGDEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_ce,
    input  logic [2*IFFT_OWIDTH-1:0] i_result,
    input  logic                     i_sync,
    ifft_codec_packer_if.master      codec,
    input  logic                     i_clear,
    output logic                     o_frame_done,
    output logic                     o_clipped,
    output logic                     o_overflow,
    output logic                     o_sync_err,
    output logic [LGDEPTH:0]         o_level,
    output state_t                   o_state
);

    localparam logic signed [IFFT_OWIDTH:0] RND   = (IFFT_OWIDTH+1)'(1) << (SHIFT-1);
    localparam logic signed [IFFT_OWIDTH:0] Q_MAX = (IFFT_OWIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [IFFT_OWIDTH:0] Q_MIN = ~Q_MAX;

    state_t               state;
    state_t               next_state;
    logic [LGWIDTH-1:0]   next_idx;
    logic [LGWIDTH-1:0]   samp_idx;
    logic                 accept;
    logic                 sync_err_set;

    logic signed [IFFT_OWIDTH-1:0] re;
    logic signed [IFFT_OWIDTH:0]   re_ext;
    logic                          unused_im;

    logic                          s1_valid;
    logic                          s1_last;
    logic signed [IFFT_OWIDTH:0]   s1_sum;
    logic signed [IFFT_OWIDTH:0]   q;
    logic                          sat_hi;
    logic                          sat_lo;
    logic                          clip_set;

    logic                          s2_valid;
    logic                          s2_last;
    logic signed [OUT_WIDTH-1:0]   s2_data;

    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_pop;
    logic [OUT_WIDTH-1:0]          fifo_head;
    logic                          ovf_set;

    assign re        = i_result[2*IFFT_OWIDTH-1:IFFT_OWIDTH];
    assign re_ext    = {re[IFFT_OWIDTH-1], re};
    assign unused_im = ^i_result[IFFT_OWIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_SYNC;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if ((state == WAIT_SYNC) && i_ce && i_sync) begin
            next_state = RUN;
        end
    end

    // A sync in RUN always restarts the frame; it is an error unless the
    // frame had just completed.
    always_comb begin
        accept       = 1'b0;
        samp_idx     = next_idx;
        sync_err_set = 1'b0;
        case (state)
            WAIT_SYNC: begin
                accept   = i_ce && i_sync;
                samp_idx = '0;
            end
            RUN: begin
                accept = i_ce;
                if (i_sync) begin
                    samp_idx     = '0;
                    sync_err_set = i_ce && (next_idx != '0);
                end
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    assign o_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_idx <= '0;
        end else if (accept) begin
            next_idx <= samp_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= accept;
            s1_last  <= &samp_idx;
            s1_sum   <= re_ext + RND;
        end
    end

    assign q        = s1_sum >>> SHIFT;
    assign sat_hi   = (q > Q_MAX);
    assign sat_lo   = (q < Q_MIN);
    assign clip_set = s1_valid && (sat_hi || sat_lo);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (sat_hi) begin
                s2_data <= {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end else if (sat_lo) begin
                s2_data <= {1'b1, {(OUT_WIDTH-1){1'b0}}};
            end else begin
                s2_data <= q[OUT_WIDTH-1:0];
            end
        end
    end

    assign o_frame_done = s2_valid && s2_last;

    assign fifo_pop = codec.o_valid && codec.i_ready;
    assign ovf_set  = s2_valid && fifo_full && !fifo_pop;

    dj_sample_fifo #(
        .WIDTH   (OUT_WIDTH),
        .LGDEPTH (LGDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s2_valid),
        .push_data (s2_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_level)
    );

    assign codec.o_valid  = !fifo_empty;
    assign codec.o_stream = fifo_head;

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_clipped  <= 1'b0;
            o_overflow <= 1'b0;
            o_sync_err <= 1'b0;
        end else begin
            o_clipped  <= clip_set     | (o_clipped  & ~i_clear);
            o_overflow <= ovf_set      | (o_overflow & ~i_clear);
            o_sync_err <= sync_err_set | (o_sync_err & ~i_clear);
        end
    end

endmodule

// File: tb/tb_ifft_codec_packer.sv
// Self-checking bench for ifft_codec_packer: behavioural frame/FIFO model
// compared against the DUT every cycle, plus directed scenario checks.
module tb_ifft_codec_packer;
    import dj_pkg::*;

    localparam int IW    = 26;
    localparam int OW    = 16;
    localparam int SHIFT = 10;
    localparam int LGW   = 9;
    localparam int LGD   = 4;
    localparam int FRAME = 1 << LGW;
    localparam int DEPTH = 1 << LGD;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            i_ce = 1'b0;
    logic            i_sync = 1'b0;
    logic            i_clear = 1'b0;
    logic [2*IW-1:0] i_result = '0;
    logic            o_frame_done;
    logic            o_clipped;
    logic            o_overflow;
    logic            o_sync_err;
    logic [LGD:0]    o_level;
    state_t          o_state;
    logic [OW-1:0]   stream_u;

    ifft_codec_packer_if #(.OUT_WIDTH(OW)) cif ();

    ifft_codec_packer #(
        .IFFT_OWIDTH (IW),
        .OUT_WIDTH   (OW),
        .SHIFT       (SHIFT),
        .LGWIDTH     (LGW),
        .LGDEPTH     (LGD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_ce         (i_ce),
        .i_result     (i_result),
        .i_sync       (i_sync),
        .codec        (cif),
        .i_clear      (i_clear),
        .o_frame_done (o_frame_done),
        .o_clipped    (o_clipped),
        .o_overflow   (o_overflow),
        .o_sync_err   (o_sync_err),
        .o_level      (o_level),
        .o_state      (o_state)
    );

    assign stream_u = cif.o_stream;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / counters ----------------
    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int pop_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected codec sample for a real part: floor((re + half) / 2^SHIFT), saturated.
    function automatic logic [OW:0] model_sample(input longint re);
        longint div;
        longint num;
        longint q;
        longint vmax;
        div  = longint'(1) << SHIFT;
        vmax = (longint'(1) << (OW-1)) - 1;
        num  = re + div / 2;
        q    = num / div;
        if ((num < 0) && ((num % div) != 0)) q = q - 1;
        if (q > vmax) return {1'b1, 1'b0, {(OW-1){1'b1}}};
        if (q < -vmax - 1) return {1'b1, 1'b1, {(OW-1){1'b0}}};
        return {1'b0, q[OW-1:0]};
    endfunction

    typedef struct {
        int            t;
        logic [OW-1:0] data;
        bit            clip;
        bit            last;
    } pipe_t;

    pipe_t         pipe_q[$];
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] last_pop = '0;
    bit            m_synced = 0;
    int            m_next = 0;
    bit            m_clip = 0;
    bit            m_ov = 0;
    bit            m_serr = 0;
    bit            m_fd = 0;
    int            cyc = 0;

    // Reference model: one step per clock edge, using the inputs as sampled there.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_q.delete();
            exp_q.delete();
            last_pop = '0;
            m_synced = 0;
            m_next   = 0;
            m_clip   = 0;
            m_ov     = 0;
            m_serr   = 0;
            m_fd     = 0;
        end else begin : step
            bit    pop;
            bit    cset;
            bit    oset;
            bit    sset;
            bit    acc;
            int    idx;
            pipe_t p;
            cyc++;
            m_fd = 0;
            cset = 0;
            oset = 0;
            sset = 0;
            acc  = 0;
            idx  = 0;
            pop  = (exp_q.size() > 0) && cif.i_ready;
            if (pop) last_pop = exp_q.pop_front();
            foreach (pipe_q[i]) begin
                if (pipe_q[i].t + 1 == cyc) begin
                    cset = cset | pipe_q[i].clip;
                    m_fd = m_fd | pipe_q[i].last;
                end
            end
            if ((pipe_q.size() > 0) && (pipe_q[0].t + 2 == cyc)) begin
                p = pipe_q.pop_front();
                if (exp_q.size() < DEPTH) exp_q.push_back(p.data);
                else oset = 1;
            end
            if (i_ce) begin
                if (!m_synced) begin
                    if (i_sync) begin
                        acc = 1;
                        idx = 0;
                        m_synced = 1;
                    end
                end else begin
                    acc = 1;
                    if (i_sync) begin
                        if (m_next != 0) sset = 1;
                        idx = 0;
                    end else begin
                        idx = m_next;
                    end
                end
            end
            if (acc) begin
                p.t = cyc;
                {p.clip, p.data} = model_sample(longint'($signed(i_result[2*IW-1:IW])));
                p.last = (idx == FRAME - 1);
                pipe_q.push_back(p);
                m_next = (idx + 1) % FRAME;
            end
            m_clip = cset | (m_clip & !i_clear);
            m_ov   = oset | (m_ov & !i_clear);
            m_serr = sset | (m_serr & !i_clear);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("valid", cif.o_valid, exp_q.size() > 0);
        check("level", o_level, exp_q.size());
        check("stream", stream_u, (exp_q.size() > 0) ? exp_q[0] : last_pop);
        check("frame_done", o_frame_done, m_fd);
        check("clipped", o_clipped, m_clip);
        check("overflow", o_overflow, m_ov);
        check("sync_err", o_sync_err, m_serr);
        if (o_frame_done) fd_count++;
        if (cif.o_valid && cif.i_ready) pop_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit ce, input bit sync, input longint re);
        i_ce     = ce;
        i_sync   = sync;
        i_result = {IW'(re), IW'($urandom)};
        @(posedge clk);
        #1;
        i_ce   = 1'b0;
        i_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
    endtask

    function automatic longint rand_re();
        logic signed [IW-1:0] r;
        case ($urandom_range(0, 3))
            0: rand_re = longint'($urandom_range(0, 16)) * 512 - 4096 + longint'($urandom_range(0, 2)) - 1;
            1: rand_re = (longint'(32767) << SHIFT) + longint'($urandom_range(0, 1500)) - 700;
            2: rand_re = -(longint'(32768) << SHIFT) + longint'($urandom_range(0, 1500)) - 200;
            default: begin
                r = IW'($urandom);
                rand_re = longint'(r);
            end
        endcase
        if (rand_re > (longint'(1) << (IW-1)) - 1) rand_re = (longint'(1) << (IW-1)) - 1;
        if (rand_re < -(longint'(1) << (IW-1))) rand_re = -(longint'(1) << (IW-1));
    endfunction

    // ---------------- stimulus ----------------
    int f0;
    int p0;

    initial begin
        cif.i_ready = 1'b1;

        check("pin_5120", 32'(model_sample(5120)), 32'h00005);
        check("pin_1535", 32'(model_sample(1535)), 32'h00001);
        check("pin_1536", 32'(model_sample(1536)), 32'h00002);
        check("pin_m1536", 32'(model_sample(-1536)), 32'h0FFFF);
        check("pin_m1537", 32'(model_sample(-1537)), 32'h0FFFE);
        check("pin_max", 32'(model_sample(33554431)), 32'h17FFF);
        check("pin_min", 32'(model_sample(-33554432)), 32'h08000);

        idle(3);
        check("rst_valid", cif.o_valid, 0);
        check("rst_level", o_level, 0);
        check("rst_stream", stream_u, 0);
        check("rst_state", o_state, WAIT_SYNC);
        reset = 1'b1;
        idle(2);

        // Samples without sync are discarded.
        repeat (5) drive(1, 0, rand_re());
        idle(4);
        check("nosync_level", o_level, 0);
        check("nosync_valid", cif.o_valid, 0);
        drive(1, 1, 5120);
        check("run_state", o_state, RUN);
        idle(1);
        check("lat_valid_early", cif.o_valid, 0);
        idle(1);
        check("lat_valid", cif.o_valid, 1);
        check("lat_stream", stream_u, 16'd5);
        idle(3);

        // Rounding ties.
        drive(1, 0, 1535);
        drive(1, 0, 1536);
        drive(1, 0, -1536);
        drive(1, 0, -1537);
        idle(6);
        check("round_noclip", o_clipped, 0);

        // Saturation and clear.
        drive(1, 0, 33554431);
        drive(1, 0, -33554432);
        idle(6);
        check("clip_set", o_clipped, 1);
        pulse_clear();
        check("clip_clear", o_clipped, 0);

        // Overflow with a stalled sink.
        cif.i_ready = 1'b0;
        repeat (20) drive(1, 0, rand_re());
        idle(3);
        check("ovf_level", o_level, DEPTH);
        check("ovf_flag", o_overflow, 1);
        p0 = pop_count;
        cif.i_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", cif.o_valid, 1);
            idle(1);
        end
        check("drain_empty", cif.o_valid, 0);
        check("drain_pops", pop_count - p0, DEPTH);
        pulse_clear();

        // Full frame after a (mid-frame) resync.
        f0 = fd_count;
        drive(1, 1, rand_re());
        for (int i = 1; i < FRAME; i++) drive(1, 0, rand_re());
        check("fd_not_yet", o_frame_done, 0);
        idle(1);
        check("fd_pulse", o_frame_done, 1);
        idle(1);
        check("fd_one_cycle", o_frame_done, 0);
        idle(2);
        check("fd_count", fd_count - f0, 1);
        check("resync_err", o_sync_err, 1);
        pulse_clear();

        // Sync on a frame boundary is fine; sync at index 100 is an error.
        drive(1, 1, rand_re());
        check("sync_ok", o_sync_err, 0);
        for (int i = 1; i < 100; i++) drive(1, 0, rand_re());
        drive(1, 1, rand_re());
        check("sync_err100", o_sync_err, 1);
        f0 = fd_count;
        for (int i = 1; i < FRAME - 1; i++) drive(1, 0, rand_re());
        idle(3);
        check("fd_none_early", fd_count - f0, 0);
        drive(1, 0, rand_re());
        idle(1);
        check("fd_after_resync", o_frame_done, 1);
        idle(3);
        pulse_clear();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            i_ce        = ($urandom_range(0, 9) < 7);
            i_sync      = ($urandom_range(0, 199) == 0);
            i_clear     = ($urandom_range(0, 31) == 0);
            cif.i_ready = ($urandom_range(0, 1) == 1);
            i_result    = {IW'(rand_re()), IW'($urandom)};
            @(posedge clk);
            #1;
        end
        i_ce        = 1'b0;
        i_sync      = 1'b0;
        i_clear     = 1'b0;
        cif.i_ready = 1'b1;
        idle(24);

        // Asynchronous reset mid-frame.
        cif.i_ready = 1'b0;
        drive(1, 1, rand_re());
        repeat (9) drive(1, 0, rand_re());
        idle(3);
        check("pre_rst_level", o_level, 10);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", cif.o_valid, 0);
        check("arst_level", o_level, 0);
        check("arst_stream", stream_u, 0);
        check("arst_flags", {o_clipped, o_overflow, o_sync_err, o_frame_done}, 0);
        check("arst_state", o_state, WAIT_SYNC);
        idle(2);
        reset = 1'b1;
        cif.i_ready = 1'b1;
        repeat (3) drive(1, 0, rand_re());
        idle(4);
        check("post_rst_level", o_level, 0);
        check("post_rst_state", o_state, WAIT_SYNC);
        drive(1, 1, 5120);
        idle(2);
        check("post_rst_stream", stream_u, 16'd5);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
